// File: rtl/fix_decoder_arbiter.sv
// Round-robin arbiter sharing one fix_decoder between NUM_REQ RX channels.
// Grants a channel, issues its frame, waits for decode or timeout, reports back.
module fix_decoder_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int FRAME_W        = 2096,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*FRAME_W-1:0]   req_frame,
   input  logic [NUM_REQ-1:0]           lock_clear,
   output logic                         dec_rx_enable,
   output logic [FRAME_W-1:0]           dec_frame,
   input  logic                         dec_is_decoded,
   input  logic [7:0]                   dec_msg_type,
   input  logic                         dec_fatal_error,
   output logic [NUM_REQ-1:0]           done,
   output logic [7:0]                   done_msg_type,
   output logic                         done_fatal,
   output logic                         done_timeout,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic [NUM_REQ-1:0]           locked
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef logic [IDW-1:0] id_t;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t              state_q, state_d;
   id_t                 rr_ptr;
   id_t                 pick;
   id_t                 idx;
   logic                pick_valid;
   logic [NUM_REQ-1:0]  elig;
   logic [NUM_REQ-1:0]  grant_onehot;
   logic [CW-1:0]       wait_cnt;

   function automatic id_t next_id(input id_t i);
      if (i == IDW'(NUM_REQ - 1)) return '0;
      else                        return i + IDW'(1);
   endfunction

   assign elig         = req & ~locked;
   assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

   // First eligible channel found walking cyclically from rr_ptr.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      pick       = '0;
      pick_valid = 1'b0;
      idx        = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_valid && elig[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
         idx = next_id(idx);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      dec_rx_enable = 1'b0;
      busy          = 1'b1;
      done          = '0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (pick_valid) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            dec_rx_enable = 1'b1;
            state_d       = S_WAIT;
         end
         S_WAIT: begin
            if (dec_is_decoded || wait_cnt == CNT_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            done    = grant_onehot;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr        <= '0;
         grant_id      <= '0;
         dec_frame     <= '0;
         wait_cnt      <= '0;
         done_msg_type <= '0;
         done_fatal    <= 1'b0;
         done_timeout  <= 1'b0;
         locked        <= '0;
      end else begin
         // A fatal completion locking a channel overrides a same-cycle clear.
         locked <= (locked & ~lock_clear) |
                   ((state_q == S_DONE && done_fatal) ? grant_onehot : '0);
         case (state_q)
            S_IDLE: begin
               if (pick_valid) begin
                  grant_id  <= pick;
                  dec_frame <= req_frame[pick*FRAME_W +: FRAME_W];
                  rr_ptr    <= next_id(pick);
               end
            end
            S_ISSUE: wait_cnt <= '0;
            S_WAIT: begin
               if (dec_is_decoded) begin
                  done_msg_type <= dec_msg_type;
                  done_fatal    <= dec_fatal_error;
                  done_timeout  <= 1'b0;
               end else if (wait_cnt == CNT_LAST) begin
                  done_msg_type <= '0;
                  done_fatal    <= 1'b0;
                  done_timeout  <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fix_decoder_arbiter.md
Name: fix_decoder_arbiter

Overview:
Shares one fix_decoder instance between NUM_REQ receive channels (one per FIX session RX buffer). It selects a requester round-robin, latches its raw frame, pulses the decoder's rx_enable, and waits for is_decoded or a timeout. It then returns msg_type and error status to the granted requester. A requester whose frame raises fatal_error is locked out until its session logic clears it. The block sits between the per-session RX framers and fix_decoder.

Parameters:
NUM_REQ, 4, number of requesting channels (2..8)
FRAME_W, 2096, raw frame width in bits ((220+42)*8), matches decoder input
TIMEOUT_CYCLES, 64, max cycles in WAIT before abandoning a decode (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-channel decode request; level, held until matching done
req_frame  in  NUM_REQ*FRAME_W  per-channel frames, channel i at bits [i*FRAME_W +: FRAME_W]
lock_clear  in  NUM_REQ  per-channel pulse, clears lockout
dec_rx_enable  out  1  one-cycle start pulse to decoder
dec_frame  out  FRAME_W  latched frame to decoder fix_pre_decode
dec_is_decoded  in  1  decoder completion
dec_msg_type  in  8  decoder message type
dec_fatal_error  in  1  decoder fatal error
done  out  NUM_REQ  one-hot, one-cycle completion pulse to granted channel
done_msg_type  out  8  msg_type of last completed job
done_fatal  out  1  last job reported fatal_error
done_timeout  out  1  last job timed out
grant_id  out  $clog2(NUM_REQ)  index of current or last granted channel
busy  out  1  high in every state except IDLE
locked  out  NUM_REQ  current lockout mask

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE, rr_ptr=0, locked=0, all outputs 0, dec_frame=0, wait counter=0.
  - Reset mid-operation abandons the job: no done pulse is issued and the decoder is not notified.
- Eligible requesters: elig = req & ~locked.
- FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If elig != 0, grant the first set bit of elig, searching cyclically from rr_ptr.
  - Capture grant_id, latch dec_frame from that channel's req_frame slice, set rr_ptr <= (gid+1) mod NUM_REQ, go to ISSUE.
  - If elig == 0, stay in IDLE.
- ISSUE: dec_rx_enable=1 for exactly this cycle, clear the wait counter, go to WAIT. dec_frame stays stable from ISSUE through DONE.
- WAIT:
  - If dec_is_decoded=1: latch done_msg_type=dec_msg_type, done_fatal=dec_fatal_error, done_timeout=0, go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: done_timeout=1, done_fatal=0, done_msg_type=0, go to DONE.
  - Else increment the counter.
  - If is_decoded and the timeout fall in the same cycle, is_decoded wins.
- DONE:
  - done[grant_id]=1 for this cycle only, then go to IDLE.
  - If done_fatal=1, set locked[grant_id].
  - The done_* and grant_id registers hold their values until the next job's capture.
- Minimum latency: req rising in IDLE -> dec_rx_enable 1 cycle later. Decoder answering the cycle after ISSUE -> done 3 cycles after grant.
- dec_is_decoded, dec_fatal_error and dec_msg_type are ignored outside WAIT.
- req deasserting after grant has no effect: the job completes and done still pulses.
- lock_clear[i] clears locked[i] any cycle. If DONE sets the same bit in the same cycle, set wins.
- A locked channel's req is ignored and it never gets done until cleared.
- Back-to-back: a requester still asserting req after its done is eligible again. Round-robin guarantees each other eligible channel is granted first.

Test Plan:
- NUM_REQ=4, TIMEOUT=16, req=4'b0100, decoder returns is_decoded with msg_type=8'h41 ('A') two cycles after rx_enable -> dec_rx_enable pulses 1 cycle after req, done=4'b0100 one cycle, done_msg_type=8'h41, done_fatal=0, done_timeout=0, grant_id=2.
- req=4'b1111 held, decoder always answers -> grant order 0,1,2,3,0; each done is one-hot, and no channel is granted twice before the others.
- req=4'b0001, decoder never answers -> done[0] pulses exactly 16 cycles after entering WAIT with done_timeout=1, done_msg_type=0.
- Channel 1 job returns fatal_error=1 -> done_fatal=1, locked=4'b0010, and further req[1] is ignored while channel 3 still gets service. A lock_clear[1] pulse -> locked=0 and channel 1 is granted again.
- is_decoded asserted in the same cycle the counter reaches 15 -> done_timeout=0 and msg_type latched. is_decoded asserted during IDLE -> no effect.
- rst=1 asserted in WAIT -> next cycle state IDLE, busy=0, done=0, locked=0, rr_ptr=0, and no done pulse.
